axis_pkt_gen: RTL

Parametrised AXI4-Stream packet generator: the next generation of `axis_data_gen`. It emits fixed-length packets at a programmable start-to-start period into the 400GbE TX streaming path. Over `axis_data_gen` it adds:
- byte-exact lengths via last-beat `tkeep`
- full `tready` backpressure
- selectable payload modes
- a bounded packet count
- status counters, including late-start detection

---
 rtl/axis_pkt_gen_pkg.sv | 25 ++
 rtl/axis_pkt_gen_payload.sv | 47 ++++
 rtl/axis_pkt_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream packet generator.
package axis_pkt_gen_pkg;

   localparam int unsigned LANE_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap,
      StDone
   } state_e;

   localparam logic [1:0] MODE_COUNT = 2'd0;
   localparam logic [1:0] MODE_CONST = 2'd1;
   localparam logic [1:0] MODE_LFSR  = 2'd2;

   // x^32 + x^22 + x^2 + x + 1, x^32 term implicit
   localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {l[30:0], 1'b0} ^ (l[31] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/axis_pkt_gen_payload.sv
// Combinational beat payload and byte enables; the parent registers the result.
module axis_pkt_gen_payload
   import axis_pkt_gen_pkg::*;
#(
   parameter int unsigned G_AXIS_DATA_WIDTH = 1024,
   parameter int unsigned G_LEN_WIDTH       = 16
) (
   input  logic [1:0]                     mode,
   input  logic [31:0]                    pattern,
   input  logic [15:0]                    seq,
   input  logic [G_LEN_WIDTH-1:0]         beat,
   input  logic [31:0]                    lfsr,
   input  logic                           last,
   input  logic [G_LEN_WIDTH-1:0]         len,
   output logic [G_AXIS_DATA_WIDTH-1:0]   tdata,
   output logic [G_AXIS_DATA_WIDTH/8-1:0] tkeep
);

   localparam int unsigned BYTES = G_AXIS_DATA_WIDTH / 8;
   localparam int unsigned LANES = G_AXIS_DATA_WIDTH / LANE_W;

   logic [G_LEN_WIDTH-1:0]       rem;
   logic [15:0]                  idx;
   logic [G_AXIS_DATA_WIDTH-1:0] raw;

   always_comb begin
      rem   = G_LEN_WIDTH'(32'(len) % BYTES);
      idx   = '0;
      raw   = '0;
      tkeep = '0;
      tdata = '0;
      for (int k = 0; k < LANES; k++) begin
         idx = 16'(32'(beat) * LANES + 32'(k));
         case (mode)
            MODE_CONST: raw[k*LANE_W +: LANE_W] = pattern;
            MODE_LFSR:  raw[k*LANE_W +: LANE_W] = lfsr ^ 32'(k);
            default:    raw[k*LANE_W +: LANE_W] = {seq, idx};
         endcase
      end
      // Only a short last beat trims tkeep; disabled bytes are zeroed.
      for (int i = 0; i < BYTES; i++) begin
         tkeep[i]        = !last || (rem == '0) || (G_LEN_WIDTH'(i) < rem);
         tdata[i*8 +: 8] = tkeep[i] ? raw[i*8 +: 8] : 8'h00;
      end
   end

endmodule

// File: rtl/axis_pkt_gen.sv
// Fixed-length AXI4-Stream packet generator with programmable start-to-start period,
// backpressure, bounded packet count and status counters.
module axis_pkt_gen
   import axis_pkt_gen_pkg::*;
#(
   parameter int unsigned G_AXIS_DATA_WIDTH = 1024,
   parameter int unsigned G_LEN_WIDTH       = 16,
   parameter int unsigned G_CNT_WIDTH       = 32
) (
   input  logic                           axis_streaming_data_clk,
   input  logic                           axis_streaming_arst,
   input  logic                           axis_data_gen_enable,
   input  logic [G_LEN_WIDTH-1:0]         pkt_length,
   input  logic [G_CNT_WIDTH-1:0]         period,
   input  logic [G_CNT_WIDTH-1:0]         pkt_count,
   input  logic [1:0]                     mode,
   input  logic [31:0]                    pattern,
   output logic [G_AXIS_DATA_WIDTH-1:0]   axis_streaming_data_tx_tdata,
   output logic                           axis_streaming_data_tx_tvalid,
   output logic                           axis_streaming_data_tx_tuser,
   output logic [G_AXIS_DATA_WIDTH/8-1:0] axis_streaming_data_tx_tkeep,
   output logic                           axis_streaming_data_tx_tlast,
   input  logic                           axis_streaming_data_tx_tready,
   output logic [G_CNT_WIDTH-1:0]         pkts_sent,
   output logic [G_CNT_WIDTH-1:0]         late_count,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned BYTES = G_AXIS_DATA_WIDTH / 8;
   localparam int unsigned CMP_W = (G_CNT_WIDTH > G_LEN_WIDTH ? G_CNT_WIDTH : G_LEN_WIDTH) + 1;

   function automatic logic [G_LEN_WIDTH-1:0] beats_of(input logic [G_LEN_WIDTH-1:0] len);
      return G_LEN_WIDTH'((32'(len) + BYTES - 32'd1) / BYTES);
   endfunction

   state_e                       state_q;
   logic [G_LEN_WIDTH-1:0]       len_q, beat_q;
   logic [G_CNT_WIDTH-1:0]       period_q, cnt_q, pkts_sent_q, late_q;
   logic [1:0]                   mode_q;
   logic [31:0]                  pattern_q, lfsr_q;
   logic [15:0]                  seq_q;
   logic                         tvalid_q, tuser_q, tlast_q, busy_q, done_q;
   logic [G_AXIS_DATA_WIDTH-1:0] tdata_q;
   logic [BYTES-1:0]             tkeep_q;

   logic                         hs, last_hs, expired, late, start_ok, last_pkt;
   logic [G_CNT_WIDTH-1:0]       pkts_inc;
   logic [31:0]                  lfsr_d;
   logic                         ld_first, ld_next, ld_new, ld_last;
   logic [G_LEN_WIDTH-1:0]       ld_len, ld_beat;
   logic [1:0]                   ld_mode;
   logic [31:0]                  ld_pattern;
   logic [15:0]                  ld_seq;
   logic [G_AXIS_DATA_WIDTH-1:0] pl_data;
   logic [BYTES-1:0]             pl_keep;

   always_comb begin
      hs       = tvalid_q & axis_streaming_data_tx_tready;
      last_hs  = hs & tlast_q;
      // Next start is due at the following cycle once cnt reaches period-1.
      expired  = (CMP_W'(cnt_q) + CMP_W'(1)) >= CMP_W'(period_q);
      late     = (CMP_W'(cnt_q) >= CMP_W'(period_q)) &&
                 (CMP_W'(period_q) > CMP_W'(beats_of(len_q)));
      start_ok = axis_data_gen_enable && (pkt_length != '0);
      pkts_inc = pkts_sent_q + G_CNT_WIDTH'(1);
      last_pkt = (pkt_count != '0) && (pkts_inc >= pkt_count);
      lfsr_d   = hs ? lfsr_step(lfsr_q) : lfsr_q;

      ld_first = (state_q == StSend) && !tvalid_q;
      ld_next  = hs && !tlast_q;
      ld_new   = start_ok && expired &&
                 (((state_q == StSend) && last_hs && !last_pkt) || (state_q == StGap));

      ld_len     = len_q;
      ld_mode    = mode_q;
      ld_pattern = pattern_q;
      ld_seq     = seq_q;
      ld_beat    = ld_first ? '0 : beat_q + G_LEN_WIDTH'(1);
      if (ld_new) begin
         ld_len     = pkt_length;
         ld_mode    = mode;
         ld_pattern = pattern;
         ld_seq     = seq_q + 16'd1;
         ld_beat    = '0;
      end
      ld_last = (ld_beat == beats_of(ld_len) - G_LEN_WIDTH'(1));
   end

   axis_pkt_gen_payload #(
      .G_AXIS_DATA_WIDTH (G_AXIS_DATA_WIDTH),
      .G_LEN_WIDTH       (G_LEN_WIDTH)
   ) u_payload (
      .mode    (ld_mode),
      .pattern (ld_pattern),
      .seq     (ld_seq),
      .beat    (ld_beat),
      .lfsr    (lfsr_d),
      .last    (ld_last),
      .len     (ld_len),
      .tdata   (pl_data),
      .tkeep   (pl_keep)
   );

   always_ff @(posedge axis_streaming_data_clk or negedge axis_streaming_arst) begin
      if (!axis_streaming_arst) begin
         state_q     <= StIdle;
         len_q       <= '0;
         beat_q      <= '0;
         period_q    <= '0;
         cnt_q       <= '0;
         pkts_sent_q <= '0;
         late_q      <= '0;
         mode_q      <= '0;
         pattern_q   <= '0;
         lfsr_q      <= '0;
         seq_q       <= '0;
         tvalid_q    <= 1'b0;
         tuser_q     <= 1'b0;
         tlast_q     <= 1'b0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         if (cnt_q != '1) begin
            cnt_q <= cnt_q + G_CNT_WIDTH'(1);
         end
         if (ld_first || ld_next || ld_new) begin
            tvalid_q <= 1'b1;
            tdata_q  <= pl_data;
            tkeep_q  <= pl_keep;
            tuser_q  <= (ld_beat == '0);
            tlast_q  <= ld_last;
            beat_q   <= ld_beat;
         end else if (hs) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
         end
         if (ld_first || ld_new) begin
            cnt_q <= '0;
         end
         if (ld_new) begin
            len_q     <= pkt_length;
            period_q  <= period;
            mode_q    <= mode;
            pattern_q <= pattern;
            seq_q     <= ld_seq;
         end
         if (last_hs) begin
            pkts_sent_q <= pkts_inc;
            if (late) begin
               late_q <= late_q + G_CNT_WIDTH'(1);
            end
         end

         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q     <= StSend;
                  busy_q      <= 1'b1;
                  pkts_sent_q <= '0;
                  late_q      <= '0;
                  seq_q       <= '0;
                  lfsr_q      <= LFSR_SEED;
                  len_q       <= pkt_length;
                  period_q    <= period;
                  mode_q      <= mode;
                  pattern_q   <= pattern;
               end
            end
            StSend: begin
               if (last_hs) begin
                  if (last_pkt) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else if (!start_ok) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else if (!expired) begin
                     state_q <= StGap;
                  end
               end
            end
            StGap: begin
               if (!axis_data_gen_enable || (expired && !start_ok)) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (expired) begin
                  state_q <= StSend;
               end
            end
            StDone: begin
               if (!axis_data_gen_enable) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign axis_streaming_data_tx_tdata  = tdata_q;
   assign axis_streaming_data_tx_tvalid = tvalid_q;
   assign axis_streaming_data_tx_tuser  = tuser_q;
   assign axis_streaming_data_tx_tkeep  = tkeep_q;
   assign axis_streaming_data_tx_tlast  = tlast_q;
   assign pkts_sent                     = pkts_sent_q;
   assign late_count                    = late_q;
   assign busy                          = busy_q;
   assign done                          = done_q;

endmodule
